// File: rtl/nn_pkg.sv
// Purpose: shared widths, backprop FSM states and saturation helpers for the nn datapath blocks.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package nn_pkg;

    localparam int W_W       = 8;   // signed weight width
    localparam int X_W       = 10;  // unsigned hidden activation width
    localparam int F_W       = 23;  // unsigned forward-pass result width
    localparam int T_W       = 4;   // unsigned training target width
    localparam int ERR_W     = 16;  // signed error register width
    localparam int TGT_SHIFT = 8;   // target scaled up to the final_i scale
    localparam int LR_SHIFT  = 8;   // learning rate 2^-LR_SHIFT

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ERR  = 3'd1,
        UPD  = 3'd2,
        DONE = 3'd3,
        WAIT = 3'd4
    } owu_state_t;

    // Clamp a signed value into the range of a signed 'width'-bit number.
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                      input int                  width);
        logic signed [31:0] max_v;
        logic signed [31:0] min_v;
        max_v = (32'sd1 <<< (width - 1)) - 32'sd1;
        min_v = -(32'sd1 <<< (width - 1));
        if (value > max_v)
            return max_v;
        else if (value < min_v)
            return min_v;
        else
            return value;
    endfunction

    // Error difference is formed at F_W+2 signed bits, then clamped to ERR_W.
    function automatic logic signed [ERR_W-1:0] clamp_err(input logic signed [F_W+1:0] diff);
        logic signed [31:0] wide;
        wide = {{(32-F_W-2){diff[F_W+1]}}, diff};
        return ERR_W'(sat_signed(wide, ERR_W));
    endfunction

endpackage

// File: rtl/weight_update_mac.sv
// Purpose: one gradient step for a single weight: w_new = sat(w + ((err * x) >>> SH)).
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs.
// Ports: err_i signed error, x_i unsigned activation, w_i current weight, w_new_o saturated result.
module weight_update_mac
    import nn_pkg::*;
#(
    parameter int EW = ERR_W,
    parameter int XW = X_W,
    parameter int WW = W_W,
    parameter int SH = LR_SHIFT
) (
    input  logic signed [EW-1:0] err_i,
    input  logic        [XW-1:0] x_i,
    input  logic signed [WW-1:0] w_i,
    output logic signed [WW-1:0] w_new_o
);

    // Full product width: signed error times zero-extended activation.
    localparam int PW = EW + XW + 1;

    logic signed [PW-1:0] err_ext;
    logic signed [PW-1:0] x_ext;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] delta;
    logic signed [PW:0]   sum;

    // Both operands are extended to PW first; the true product always fits in PW bits.
    assign err_ext = {{(PW-EW){err_i[EW-1]}}, err_i};
    assign x_ext   = {{(PW-XW){1'b0}}, x_i};
    assign prod    = err_ext * x_ext;
    assign delta   = prod >>> SH;
    assign sum     = {delta[PW-1], delta} + {{(PW+1-WW){w_i[WW-1]}}, w_i};
    assign w_new_o = WW'(sat_signed({{(32-PW-1){sum[PW]}}, sum}, WW));

endmodule

// File: rtl/output_weight_update.sv
// Purpose: hidden-to-output backprop; computes error, updates each weight through one shared MAC, commits atomically.
// Latency: en_i sampled high -> ERR, NUM_W UPD cycles, then DONE with new weights_o and b_end_o pulse (4 edges for NUM_W=2).
// Backpressure: none; en_i low in ERR/UPD aborts, en_i held high after DONE parks in WAIT (no retrigger).
// Ports: clk_i/rst_i (sync, active-high), en_i pass enable, zero_weight_reset_i loads weights_i,
//        final_i/target_i/x_i operands (stable while busy_o), weights_o committed weights, b_end_o, busy_o.
module output_weight_update
    import nn_pkg::*;
#(
    parameter int NUM_W = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic                   zero_weight_reset_i,
    input  logic [F_W-1:0]         final_i,
    input  logic [T_W-1:0]         target_i,
    input  logic [NUM_W*X_W-1:0]   x_i,
    input  logic [NUM_W*W_W-1:0]   weights_i,
    output logic [NUM_W*W_W-1:0]   weights_o,
    output logic                   b_end_o,
    output logic                   busy_o
);

    localparam int IDX_W = (NUM_W > 1) ? $clog2(NUM_W) : 1;

    owu_state_t              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic signed [ERR_W-1:0] err_q, err_d;
    logic [NUM_W*W_W-1:0]    shadow_q, shadow_d;
    logic [NUM_W*W_W-1:0]    weights_q, weights_d;

    logic [X_W-1:0]          x_sel;
    logic signed [W_W-1:0]   w_sel;
    logic signed [W_W-1:0]   w_new;
    logic signed [F_W+1:0]   err_diff;

    // Target scaled to the final_i domain; both operands are unsigned, so zero-extend before subtracting.
    assign err_diff = $signed({{(F_W+2-T_W-TGT_SHIFT){1'b0}}, target_i, {TGT_SHIFT{1'b0}}})
                    - $signed({2'b00, final_i});

    assign x_sel = x_i[idx_q*X_W +: X_W];
    assign w_sel = weights_q[idx_q*W_W +: W_W];

    weight_update_mac #(
        .EW (ERR_W),
        .XW (X_W),
        .WW (W_W),
        .SH (LR_SHIFT)
    ) u_mac (
        .err_i   (err_q),
        .x_i     (x_sel),
        .w_i     (w_sel),
        .w_new_o (w_new)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        err_d     = err_q;
        shadow_d  = shadow_q;
        weights_d = weights_q;

        if (zero_weight_reset_i) begin
            state_d   = IDLE;
            idx_d     = '0;
            shadow_d  = '0;
            weights_d = weights_i;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en_i)
                        state_d = ERR;
                end
                ERR: begin
                    if (!en_i) begin
                        state_d = IDLE;
                    end else begin
                        err_d   = clamp_err(err_diff);
                        idx_d   = '0;
                        state_d = UPD;
                    end
                end
                UPD: begin
                    if (!en_i) begin
                        // Aborted pass: committed weights untouched, partial shadow ignored.
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        shadow_d[idx_q*W_W +: W_W] = w_new;
                        if (idx_q == IDX_W'(NUM_W - 1)) begin
                            // The last weight bypasses the shadow so the commit lands this edge.
                            weights_d                   = shadow_q;
                            weights_d[idx_q*W_W +: W_W] = w_new;
                            state_d                     = DONE;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_d = en_i ? WAIT : IDLE;
                end
                WAIT: begin
                    if (!en_i)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            err_q     <= '0;
            shadow_q  <= '0;
            weights_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            shadow_q  <= shadow_d;
            weights_q <= weights_d;
        end
    end

    assign weights_o = weights_q;
    assign b_end_o   = (state_q == DONE);
    assign busy_o    = (state_q == ERR) || (state_q == UPD);

endmodule

// File: tb/tb_output_weight_update.sv
// Purpose: directed self-checking bench for output_weight_update (NUM_W=2).
// Latency: inputs driven #1 after posedge, outputs checked at that same point.
// Backpressure: n/a.
module tb_output_weight_update;
    import nn_pkg::*;

    logic                 clk_i;
    logic                 rst_i;
    logic                 en_i;
    logic                 zero_weight_reset_i;
    logic [F_W-1:0]       final_i;
    logic [T_W-1:0]       target_i;
    logic [2*X_W-1:0]     x_i;
    logic [2*W_W-1:0]     weights_i;
    logic [2*W_W-1:0]     weights_o;
    logic                 b_end_o;
    logic                 busy_o;

    int checks = 0;
    int errors = 0;
    int pulses;
    int edges;

    output_weight_update #(.NUM_W(2)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .en_i                (en_i),
        .zero_weight_reset_i (zero_weight_reset_i),
        .final_i             (final_i),
        .target_i            (target_i),
        .x_i                 (x_i),
        .weights_i           (weights_i),
        .weights_o           (weights_o),
        .b_end_o             (b_end_o),
        .busy_o              (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raise en_i and count edges until b_end_o, bounded; 0 means no pulse seen.
    task automatic run_pass(output int n);
        n = 0;
        en_i = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (b_end_o === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        rst_i               = 1'b1;
        en_i                = 1'b0;
        zero_weight_reset_i = 1'b0;
        final_i             = '0;
        target_i            = '0;
        x_i                 = '0;
        weights_i           = '0;

        // Reset
        tick();
        rst_i = 1'b0;
        check("rst_weights", {16'd0, weights_o}, 32'h0);
        check("rst_b_end",   {31'd0, b_end_o},   32'h0);
        check("rst_busy",    {31'd0, busy_o},    32'h0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (b_end_o || busy_o) pulses++;
        end
        check("idle_quiet",   pulses,              32'd0);
        check("idle_weights", {16'd0, weights_o},  32'h0);

        // Load initial weights
        weights_i           = 16'h0201;
        zero_weight_reset_i = 1'b1;
        tick();
        zero_weight_reset_i = 1'b0;
        check("load_weights", {16'd0, weights_o}, 32'h0201);

        // Zero error: 4<<8 == 1024, pulse 4 edges after en_i rises, weights unchanged
        target_i = 4'd4;
        final_i  = 23'd1024;
        x_i      = {10'd0, 10'd256};
        en_i     = 1'b1;
        tick();
        check("zero_e1_busy",  {31'd0, busy_o},  32'h1);
        check("zero_e1_b_end", {31'd0, b_end_o}, 32'h0);
        tick();
        check("zero_e2_b_end", {31'd0, b_end_o}, 32'h0);
        tick();
        check("zero_e3_b_end", {31'd0, b_end_o}, 32'h0);
        tick();
        check("zero_e4_b_end",   {31'd0, b_end_o},   32'h1);
        check("zero_e4_busy",    {31'd0, busy_o},    32'h0);
        check("zero_e4_weights", {16'd0, weights_o}, 32'h0201);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (b_end_o) pulses++;
        end
        check("hold_no_retrigger", pulses, 32'd0);
        en_i = 1'b0;
        tick();

        // Small gradient: err=-8, delta0=(-8*64)>>>8=-2 -> w0=-1, w1 unchanged
        target_i = 4'd0;
        final_i  = 23'd8;
        x_i      = {10'd0, 10'd64};
        run_pass(edges);
        check("small_latency", edges,              32'd4);
        check("small_weights", {16'd0, weights_o}, 32'h02FF);
        en_i = 1'b0;
        tick();

        // Saturation: err clamps to -32768; w0=-1-32768 -> -128, w1=2-128=-126
        final_i  = 23'h7FFFFF;
        target_i = 4'd0;
        x_i      = {10'd1, 10'd256};
        en_i     = 1'b1;
        tick();
        tick();
        check("sat_err", {16'd0, dut.err_q}, 32'h8000);
        tick();
        tick();
        check("sat_b_end",   {31'd0, b_end_o},   32'h1);
        check("sat_weights", {16'd0, weights_o}, 32'h8280);
        en_i = 1'b0;
        tick();

        // Abort during UPD
        final_i  = 23'd8;
        target_i = 4'd0;
        x_i      = {10'd64, 10'd64};
        en_i     = 1'b1;
        tick();
        tick();
        check("abort_in_upd_busy", {31'd0, busy_o}, 32'h1);
        en_i = 1'b0;
        tick();
        check("abort_busy",    {31'd0, busy_o},    32'h0);
        check("abort_weights", {16'd0, weights_o}, 32'h8280);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (b_end_o) pulses++;
        end
        check("abort_no_pulse", pulses,              32'd0);
        check("abort_weights2", {16'd0, weights_o},  32'h8280);

        // zero_weight_reset_i wins over an in-flight pass in ERR
        weights_i = 16'h1234;
        en_i      = 1'b1;
        tick();
        check("zwr_in_err_busy", {31'd0, busy_o}, 32'h1);
        zero_weight_reset_i = 1'b1;
        tick();
        zero_weight_reset_i = 1'b0;
        check("zwr_weights", {16'd0, weights_o}, 32'h1234);
        check("zwr_b_end",   {31'd0, b_end_o},   32'h0);
        check("zwr_busy",    {31'd0, busy_o},    32'h0);
        en_i = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (b_end_o) pulses++;
        end
        check("zwr_no_pulse", pulses,             32'd0);
        check("zwr_weights2", {16'd0, weights_o}, 32'h1234);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
